// File: rtl/ff_mean_remove_if.sv
// ff_mean_remove_if: sample stream into and out of the mean-removal stage.
// The source drives the strobe and input samples; the stage returns the
// mean-corrected samples together with the delayed strobe.
interface ff_mean_remove_if #(
  parameter int DW = 16
) ();

  logic                 store_strb;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;
  logic                 strb_out;

  modport master (
    output store_strb,
    output din,
    input  dout,
    input  strb_out
  );

  modport slave (
    input  store_strb,
    input  din,
    output dout,
    output strb_out
  );

endinterface

// File: rtl/ff_mean_remove.sv
// ff_mean_remove: pulse-mean removal for the feed-forward DAC drive path.
// Each pulse accumulates a 2^k-sample window. At pulse end the window mean is
// stored and subtracted from every sample of the following pulses. The data
// path is two register stages: subtract, then saturate. The strobe follows
// the data through both stages.
module ff_mean_remove #(
  parameter int DW      = 16,
  parameter int MAXLOG2 = 9,
  parameter int ACCW    = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ff_mean_remove_if.slave      bus,
  input  logic                 rm_en,
  input  logic [9:0]           start_acc,
  input  logic [3:0]           log2_len,
  input  logic                 flag_clr,
  output logic signed [DW-1:0] mean_out,
  output logic                 mean_valid,
  output logic                 short_pulse,
  output logic                 oflow
);

  localparam logic [3:0]  MAXL    = 4'(MAXLOG2);
  localparam logic [9:0]  CTR_MAX = 10'h3FF;

  // Strobe history and sample index within the current pulse.
  logic                 strb_d;
  logic [9:0]           ctr;

  // Window accumulator and window-complete flag.
  logic signed [ACCW-1:0] acc;
  logic                   wc;

  // Values captured on the strobe rising edge.
  logic [3:0]           l2_lat;
  logic                 rm_lat;

  // Stored mean.
  logic signed [DW-1:0] mean_reg;

  // Output pipeline.
  logic signed [DW:0]   d1;
  logic                 s1;

  // Combinational helpers.
  logic                   rise;
  logic                   pulse_end;
  logic [3:0]             l2_clamp;
  logic [10:0]            win_len;
  logic [10:0]            win_end;
  logic [10:0]            ctr_ext;
  logic                   wc_eff;
  logic                   in_win;
  logic                   win_last;
  logic signed [ACCW-1:0] acc_base;
  logic signed [ACCW-1:0] din_ext;
  logic                   rm_eff;
  logic signed [DW-1:0]   sub_val;
  logic                   ovf_hi;
  logic                   ovf_lo;
  logic signed [DW-1:0]   sat_val;

  assign rise      = bus.store_strb & ~strb_d;
  assign pulse_end = strb_d & ~bus.store_strb;

  assign l2_clamp  = (log2_len > MAXL) ? MAXL : log2_len;
  assign win_len   = 11'd1 << l2_clamp;
  assign win_end   = {1'b0, start_acc} + win_len;
  assign ctr_ext   = {1'b0, ctr};

  // A new pulse starts from an empty window even though wc/acc still hold the
  // previous pulse until the rising-edge clock.
  assign wc_eff    = rise ? 1'b0 : wc;
  assign acc_base  = rise ? '0 : acc;

  // Once the window is complete no more samples are added. This keeps the sum
  // exact when ctr saturates at the last index of a window ending at 1023.
  assign in_win    = bus.store_strb & (ctr >= start_acc) & (ctr_ext < win_end) & ~wc_eff;
  assign win_last  = (ctr_ext == (win_end - 11'd1));

  assign din_ext   = {{(ACCW-DW){bus.din[DW-1]}}, bus.din};

  // On the rising-edge cycle the latch is not loaded yet, so use rm_en live.
  assign rm_eff    = rise ? rm_en : rm_lat;
  assign sub_val   = (rm_eff & mean_valid) ? mean_reg : '0;

  assign ovf_hi    = ~d1[DW] &  d1[DW-1];
  assign ovf_lo    =  d1[DW] & ~d1[DW-1];
  assign sat_val   = ovf_hi ? {1'b0, {(DW-1){1'b1}}} :
                     ovf_lo ? {1'b1, {(DW-1){1'b0}}} :
                              d1[DW-1:0];

  // Track the strobe and count samples. Hold 0 between pulses and saturate at 1023.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_d <= 1'b0;
      ctr    <= '0;
    end else begin
      strb_d <= bus.store_strb;
      if (!bus.store_strb)
        ctr <= '0;
      else if (ctr != CTR_MAX)
        ctr <= ctr + 10'd1;
    end
  end

  // Sum the in-window samples and flag completion when the Nth one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      wc  <= 1'b0;
    end else begin
      acc <= in_win ? (acc_base + din_ext) : acc_base;
      wc  <= wc_eff | (in_win & win_last);
    end
  end

  // Capture the per-pulse settings on the strobe rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_lat <= 1'b0;
      l2_lat <= '0;
    end else if (rise) begin
      rm_lat <= rm_en;
      l2_lat <= l2_clamp;
    end
  end

  // At pulse end, store the floor mean of a complete window. Otherwise keep the old mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_reg   <= '0;
      mean_valid <= 1'b0;
    end else if (pulse_end && wc) begin
      mean_reg   <= DW'(acc >>> l2_lat);
      mean_valid <= 1'b1;
    end
  end

  // Sticky incomplete-window flag. A clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      short_pulse <= 1'b0;
    else if (flag_clr)
      short_pulse <= 1'b0;
    else if (pulse_end && !wc)
      short_pulse <= 1'b1;
  end

  // Stage 1: subtract the mean at one bit of headroom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      s1 <= 1'b0;
    end else begin
      d1 <= {bus.din[DW-1], bus.din} - {sub_val[DW-1], sub_val};
      s1 <= bus.store_strb;
    end
  end

  // Stage 2: saturate to DW bits and blank the output outside the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout     <= '0;
      bus.strb_out <= 1'b0;
    end else begin
      bus.dout     <= s1 ? sat_val : '0;
      bus.strb_out <= s1;
    end
  end

  // Sticky saturation flag, counted only for strobed samples. A clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      oflow <= 1'b0;
    else if (flag_clr)
      oflow <= 1'b0;
    else if (s1 && (ovf_hi || ovf_lo))
      oflow <= 1'b1;
  end

  assign mean_out = mean_reg;

endmodule

// File: tb/tb_ff_mean_remove.sv
// tb_ff_mean_remove: table-driven pulse scenarios, a mid-pulse reset sequence
// and randomized pulses. Every output is compared each cycle against a
// behavioural model that works on whole pulses.
module tb_ff_mean_remove;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rm_en;
  logic flag_clr;
  logic [9:0] start_acc;
  logic [3:0] log2_len;
  logic signed [DW-1:0] mean_out;
  logic mean_valid;
  logic short_pulse;
  logic oflow;

  int errors = 0;
  int checks = 0;

  ff_mean_remove_if #(.DW(DW)) bus ();

  ff_mean_remove #(.DW(DW), .MAXLOG2(9), .ACCW(25)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rm_en       (rm_en),
    .start_acc   (start_acc),
    .log2_len    (log2_len),
    .flag_clr    (flag_clr),
    .mean_out    (mean_out),
    .mean_valid  (mean_valid),
    .short_pulse (short_pulse),
    .oflow       (oflow)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit  m_prev_strb;
  bit  m_use;
  int  m_mean;
  bit  m_valid;
  bit  m_short;
  bit  m_oflow;
  bit  m_pend_strb;
  int  m_pend_val;
  bit  m_pend_ovf;
  int  m_start;
  int  m_n;
  int  samples[$];
  int  exp_dout;
  bit  exp_strb;

  typedef struct {
    int len;
    int start;
    int l2;
    bit rm;
    bit rm_toggle;
    int a;
    int b;
    bit alt;
    int gap;
    bit clr;
    int exp_mean;
    bit exp_valid;
    bit exp_short;
    bit exp_oflow;
  } vec_t;

  vec_t vecs[$];

  function automatic void model_reset();
    m_prev_strb = 0; m_use = 0; m_mean = 0; m_valid = 0; m_short = 0; m_oflow = 0;
    m_pend_strb = 0; m_pend_val = 0; m_pend_ovf = 0; m_start = 0; m_n = 1;
    exp_dout = 0; exp_strb = 0;
    samples.delete();
  endfunction

  // Outputs expected after the coming clock edge for the given inputs.
  function automatic void model_step(input bit strb, input int din, input bit rm,
                                     input int start, input int l2, input bit clr);
    bit rise;
    bit pend;
    bit short_evt;
    bit new_oflow;
    int v;
    bit ovf;
    longint sum;
    longint q;
    logic signed [15:0] t;
    rise = strb && !m_prev_strb;
    pend = !strb && m_prev_strb;
    short_evt = 0;
    exp_strb = m_pend_strb;
    exp_dout = m_pend_strb ? m_pend_val : 0;
    new_oflow = m_oflow | (m_pend_strb & m_pend_ovf);
    if (rise) begin
      samples.delete();
      m_use = rm && m_valid;
      m_start = start;
      m_n = 1 << ((l2 > 9) ? 9 : l2);
    end
    if (strb) samples.push_back(din);
    v = din - (m_use ? m_mean : 0);
    ovf = 0;
    if (v > 32767) begin v = 32767; ovf = 1; end
    if (v < -32768) begin v = -32768; ovf = 1; end
    m_pend_strb = strb;
    m_pend_val = v;
    m_pend_ovf = ovf;
    if (pend) begin
      if ((m_start + m_n <= 1024) && (samples.size() >= m_start + m_n)) begin
        sum = 0;
        for (int k = m_start; k < m_start + m_n; k++) sum += samples[k];
        q = sum / m_n;
        if ((sum % m_n != 0) && (sum < 0)) q = q - 1;
        t = q[15:0];
        m_mean = int'(t);
        m_valid = 1;
      end else begin
        short_evt = 1;
      end
    end
    m_short = clr ? 1'b0 : (m_short | short_evt);
    m_oflow = clr ? 1'b0 : new_oflow;
    m_prev_strb = strb;
  endfunction

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check_val("dout", longint'(bus.dout), longint'(exp_dout));
    check_val("strb_out", longint'(bus.strb_out), longint'(exp_strb));
    check_val("mean_out", longint'(mean_out), longint'(m_mean));
    check_val("mean_valid", longint'(mean_valid), longint'(m_valid));
    check_val("short_pulse", longint'(short_pulse), longint'(m_short));
    check_val("oflow", longint'(oflow), longint'(m_oflow));
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the rising edge.
  task automatic apply_stimulus(input bit strb, input int din, input bit rm,
                                input int start, input int l2, input bit clr);
    bus.store_strb = strb;
    bus.din        = 16'(din);
    rm_en          = rm;
    start_acc      = 10'(start);
    log2_len       = 4'(l2);
    flag_clr       = clr;
    model_step(strb, din, rm, start, l2, clr);
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  task automatic run_vec(input vec_t v);
    int d;
    bit r;
    for (int i = 0; i < v.len; i++) begin
      d = (v.alt && (i % 2 == 1)) ? v.b : v.a;
      r = (v.rm_toggle && (i % 2 == 1)) ? !v.rm : v.rm;
      apply_stimulus(1'b1, d, r, v.start, v.l2, 1'b0);
    end
    for (int g = 0; g < v.gap; g++) begin
      apply_stimulus(1'b0, 0, 1'b0, v.start, v.l2, v.clr && (g == 1));
      if (g == 0) begin
        check_val("tbl mean_out", longint'(mean_out), longint'(v.exp_mean));
        check_val("tbl mean_valid", longint'(mean_valid), longint'(v.exp_valid));
        check_val("tbl short_pulse", longint'(short_pulse), longint'(v.exp_short));
        check_val("tbl oflow", longint'(oflow), longint'(v.exp_oflow));
      end
    end
  endtask

  initial begin
    int len, start, l2, gap, d, kind;
    bit rm;
    // len start l2 rm tog a b alt gap clr | mean valid short oflow
    vecs.push_back('{200, 10, 7, 1, 0, 1000, 0, 0, 3, 0,   1000, 1, 0, 0});
    vecs.push_back('{200, 10, 7, 1, 0, 1000, 0, 0, 3, 0,   1000, 1, 0, 0});
    vecs.push_back('{20,  0,  1, 1, 0, 3,   -4, 1, 3, 0,     -1, 1, 0, 0});
    vecs.push_back('{20,  0,  1, 1, 0, 3,   -4, 1, 3, 0,     -1, 1, 0, 0});
    vecs.push_back('{50,  40, 4, 1, 0, 77,   0, 0, 3, 1,     -1, 1, 1, 0});
    vecs.push_back('{4,   0,  0, 0, 0, -30000, 0, 0, 3, 0, -30000, 1, 0, 0});
    vecs.push_back('{10,  0,  0, 1, 0, 10000, 0, 0, 3, 1,  10000, 1, 0, 1});
    vecs.push_back('{10,  0,  0, 0, 1, 10000, 0, 0, 3, 0,  10000, 1, 0, 0});
    vecs.push_back('{520, 0, 12, 1, 0, 7,    0, 0, 3, 0,      7, 1, 0, 0});
    vecs.push_back('{1100, 1000, 5, 0, 0, 5, 0, 0, 3, 1,      7, 1, 1, 0});
    vecs.push_back('{8,   0,  2, 1, 0, 500,  0, 0, 1, 0,    500, 1, 0, 0});
    vecs.push_back('{8,   0,  2, 1, 0, 600,  0, 0, 3, 0,    600, 1, 0, 0});
    vecs.push_back('{12,  3,  3, 1, 0, -5,  -6, 1, 3, 0,     -6, 1, 0, 0});

    bus.store_strb = 1'b0;
    bus.din = '0;
    rm_en = 1'b0;
    flag_clr = 1'b0;
    start_acc = '0;
    log2_len = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset in the middle of a pulse: outputs clear at once, and the pulse
    // resumed after release passes through unmodified.
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1234, 1'b1, 0, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst dout", longint'(bus.dout), 0);
    check_val("rst strb_out", longint'(bus.strb_out), 0);
    check_val("rst mean_out", longint'(mean_out), 0);
    check_val("rst mean_valid", longint'(mean_valid), 0);
    check_val("rst short_pulse", longint'(short_pulse), 0);
    check_val("rst oflow", longint'(oflow), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'b1, 1234, 1'b1, 0, 2, 1'b0);
      if (i >= 2) check_val("post-rst dout", longint'(bus.dout), 1234);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 0, 1'b0, 0, 2, 1'b0);
    check_val("post-rst mean_out", longint'(mean_out), 1234);

    // Randomized pulses checked only against the model.
    for (int p = 0; p < 25; p++) begin
      len   = int'($urandom_range(1, 300));
      start = int'($urandom_range(0, 120));
      l2    = int'($urandom_range(0, 10));
      rm    = 1'($urandom_range(0, 1));
      gap   = int'($urandom_range(1, 4));
      kind  = int'($urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        if (kind == 0)      d = int'($urandom_range(0, 65535)) - 32768;
        else if (kind == 1) d = int'($urandom_range(0, 2000)) - 1000;
        else                d = int'($urandom_range(0, 200)) + 20000;
        apply_stimulus(1'b1, d, (i == 0) ? rm : 1'($urandom_range(0, 1)), start, l2, 1'b0);
      end
      for (int g = 0; g < gap; g++)
        apply_stimulus(1'b0, 0, 1'b0, start, l2, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_mean_remove.md
# ff_mean_remove

Pulse-mean removal stage for the feed-forward path. It sits directly upstream of the amplifier-drive stage, between the gain stage and the DAC drive input. During each strobed pulse it accumulates a 2^k-sample window of the incoming correction signal. At pulse end it computes the window mean and subtracts that mean from every sample of the following pulse, removing the static (DC) component before the signal reaches the DAC. The strobe is forwarded with the same latency as the data so downstream strobe alignment is unchanged.

## Interface
Parameters:
- DW, 16, data width of din/dout/mean_out (signed).
- MAXLOG2, 9, maximum supported log2 window length.
- ACCW, 25, accumulator width; must be ≥ DW+MAXLOG2.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- store_strb  in  1  pulse strobe; high for the duration of each pulse.
- rm_en  in  1  mean-removal enable; sampled on the store_strb rising edge only.
- start_acc  in  10  sample index within the pulse at which accumulation starts.
- log2_len  in  4  window length N = 2^log2_len; values above MAXLOG2 are clamped to MAXLOG2.
- din  in  DW  signed input sample.
- dout  out  DW  signed output sample.
- strb_out  out  1  store_strb delayed by the data latency.
- mean_out  out  DW  current stored mean.
- mean_valid  out  1  high once a complete window has been captured.
- short_pulse  out  1  sticky; set when a pulse ends with its window incomplete.
- oflow  out  1  sticky; set on output saturation.
- flag_clr  in  1  synchronous clear of short_pulse and oflow.

## Operation
- Sample counter ctr (10 bit):
  - 0 while store_strb is low; increments each cycle store_strb is high.
  - Saturates at 1023.
  - The first strobed sample has index 0.
- Accumulate window: acc += sign-extended din while store_strb=1 and start_acc ≤ ctr < start_acc+N.
  - acc is cleared on the store_strb rising edge.
  - The window-complete flag wc is set when the Nth sample is added.
  - If start_acc+N > 1024, the window never completes.
- Pulse end is the cycle in which the registered strobe is 1 and store_strb is 0.
  - If wc=1: mean_reg ← acc >>> log2_len (arithmetic shift, truncation toward −∞, low DW bits) and mean_valid ← 1.
  - If wc=0: mean_reg is held and short_pulse ← 1.
- mean_reg changes only at pulse end, so it is constant throughout any pulse.
- rm_lat ← rm_en on the store_strb rising edge; it is held for the rest of the pulse.
- Output path:
  - Stage 1: d1 = din − (rm_lat & mean_valid ? mean_reg : 0), computed at DW+1 bits.
  - Stage 2: dout = saturate d1 to [−2^(DW−1), 2^(DW−1)−1]. Saturation sets oflow.
  - dout is forced to 0 when the stage-2 strobe is low.
- flag_clr has priority over a same-cycle set: the flag reads 0.
- Reset: all registers 0. Outputs after reset: dout=0, strb_out=0, mean_out=0, mean_valid=0, short_pulse=0, oflow=0.
- Reset asserted mid-pulse aborts accumulation. After release, the first pulse passes din unmodified.

## Timing
- Latency din → dout is 2 cycles. strb_out equals store_strb delayed 2 cycles.
- mean_out/mean_valid update 1 cycle after the store_strb falling edge. The update is visible to the next pulse even if that pulse begins on the very next cycle.
- Changing start_acc or log2_len mid-pulse is unsupported. Both must be stable from the rising edge to the end of the window.
- The accumulate and subtract paths are each one adder deep per stage; timing closure at the DAC drive clock rate is required.

## Test plan
- Pulse 1: 200 samples of din=+1000, start_acc=10, log2_len=7, rm_en=1. Pulse 2: the same samples. → Pulse 1 dout=1000 (mean_valid=0). mean_out=1000 at pulse-1-end+1. Pulse 2 dout=0 throughout, strobe aligned 2 cycles late.
- din alternates +3/−4, log2_len=1, start_acc=0. → mean = (−1)>>>1 = −1. Next pulse: dout = +4 / −3.
- Pulse length 50 with start_acc=40, log2_len=4. → short_pulse=1, mean_out unchanged from its prior value. flag_clr=1 for one cycle → short_pulse=0.
- mean_out=−30000 stored; next pulse din=+10000. → dout=+32767, oflow=1. With rm_en=0 at the rising edge → dout=10000. Toggling rm_en mid-pulse has no effect.
- Assert rst_n=0 for 1 cycle mid-pulse. → All outputs 0 immediately (asynchronous). The next pulse passes din unchanged.
- Back-to-back pulses with 1 low cycle between them. → The second pulse uses the mean from the first. ctr restarts at 0.
